// File: rtl/uart_bus_master_if.sv
// CPU-bus side of the UART bus master: request/grant handshake plus single-cycle access strobe.
interface uart_bus_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        cs;
  logic        rnw;

  modport master (output bus_req, addr, dout, cs, rnw, input bus_gnt, din);
  modport slave  (input bus_req, addr, dout, cs, rnw, output bus_gnt, din);
endinterface

// File: rtl/uart_bus_master.sv
// Serial command bridge: host sends 'R'/'W' + address (+ data) over UART, block performs one bus access
// and answers with the read byte or 'K'. Define UART_BRIDGE_AUTOINC_EN for address auto-increment and 'N'.
module uart_bus_master #(
  parameter int unsigned CLKSPEED     = 26600000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned DIVISOR      = CLKSPEED / BAUD,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic txd,
  uart_bus_master_if.master bus
);

  localparam int unsigned CW       = $clog2(DIVISOR + DIVISOR / 2 + 1);
  localparam int unsigned TMO_CLKS = TIMEOUT_BITS * DIVISOR;

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {PH_REQ, PH_STROBE, PH_LATCH} phase_t;

  state_t state, state_nx;
  phase_t phase;

  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_busy, rx_valid;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;

  logic          tx_busy, tx_done, tx_start, tx_free;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_n;
  logic [8:0]    tx_sh;
  logic [7:0]    tx_data;

  logic          is_read, timed_out;
  logic          cmd_rd, cmd_wr, cmd_nx;
  logic [31:0]   tmo_cnt;

  // Synchronizer keeps running through reset so a line already low at release is not seen as a start edge.
  always_ff @(posedge clk) begin
    rx_s1   <= rxd;
    rx_s2   <= rx_s1;
    rx_prev <= rx_s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_busy  <= 1'b0;
      rx_valid <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= CW'(DIVISOR + DIVISOR / 2 - 1);
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= CW'(DIVISOR - 1);
        if (rx_bit == 4'd8) begin
          rx_busy  <= 1'b0;
          rx_valid <= rx_s2;
        end else begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
        end
      end
    end
  end

  // A new frame may be loaded on the last clock of the previous stop bit.
  assign tx_free = !tx_busy || (tx_cnt == '0 && tx_n == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      txd     <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_cnt  <= '0;
      tx_n    <= '0;
      tx_sh   <= '1;
    end else begin
      tx_done <= tx_busy && tx_cnt == '0 && tx_n == '0;
      if (tx_start && tx_free) begin
        tx_busy <= 1'b1;
        txd     <= 1'b0;
        tx_sh   <= {1'b1, tx_data};
        tx_n    <= 4'd9;
        tx_cnt  <= CW'(DIVISOR - 1);
      end else if (!tx_busy) begin
        txd <= 1'b1;
      end else if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_n == '0) begin
        tx_busy <= 1'b0;
      end else begin
        txd    <= tx_sh[0];
        tx_sh  <= {1'b1, tx_sh[8:1]};
        tx_n   <= tx_n - 1'b1;
        tx_cnt <= CW'(DIVISOR - 1);
      end
    end
  end

  assign cmd_rd    = rx_sh == 8'h52;
  assign cmd_wr    = rx_sh == 8'h57;
`ifdef UART_BRIDGE_AUTOINC_EN
  assign cmd_nx    = rx_sh == 8'h4E;
`else
  assign cmd_nx    = 1'b0;
`endif
  assign timed_out = tmo_cnt == 32'(TMO_CLKS - 1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rx_valid && (cmd_rd || cmd_wr)) state_nx = ADDR_HI;
        else if (rx_valid && cmd_nx)        state_nx = ACCESS;
      end
      ADDR_HI: begin
        if (rx_valid)       state_nx = ADDR_LO;
        else if (timed_out) state_nx = IDLE;
      end
      ADDR_LO: begin
        if (rx_valid)       state_nx = is_read ? ACCESS : DATA;
        else if (timed_out) state_nx = IDLE;
      end
      DATA: begin
        if (rx_valid)       state_nx = ACCESS;
        else if (timed_out) state_nx = IDLE;
      end
      ACCESS:  if (phase == PH_LATCH) state_nx = RESP;
      RESP:    if (tx_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req = state == ACCESS && phase != PH_LATCH;
    bus.cs      = state == ACCESS && phase == PH_STROBE;
    bus.rnw     = bus.cs ? is_read : 1'b1;
    tx_start    = (state == IDLE && rx_valid && !(cmd_rd || cmd_wr || cmd_nx))
               || (state == ACCESS && phase == PH_LATCH);
    tx_data     = (state == IDLE) ? 8'h3F : (is_read ? bus.din : 8'h4B);
  end

  // Inter-byte timer only runs while a command is partially received and the line is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.addr <= '0;
      bus.dout <= '0;
      is_read  <= 1'b1;
      phase    <= PH_REQ;
      tmo_cnt  <= '0;
    end else begin
      if (rx_busy || rx_valid || state == IDLE || state == ACCESS || state == RESP) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
      unique case (state)
        IDLE:    if (rx_valid && (cmd_rd || cmd_nx)) is_read <= 1'b1;
                 else if (rx_valid && cmd_wr)        is_read <= 1'b0;
        ADDR_HI: if (rx_valid) bus.addr[15:8] <= rx_sh;
        ADDR_LO: if (rx_valid) bus.addr[7:0]  <= rx_sh;
        DATA:    if (rx_valid) bus.dout       <= rx_sh;
        ACCESS: begin
          unique case (phase)
            PH_REQ:    if (bus.bus_gnt) phase <= PH_STROBE;
            PH_STROBE: phase <= PH_LATCH;
            default: begin
              phase <= PH_REQ;
`ifdef UART_BRIDGE_AUTOINC_EN
              bus.addr <= bus.addr + 16'd1;
`endif
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: expected bus accesses and response bytes are queued by the stimulus
// and popped by independent bus and serial monitors.
module tb_uart_bus_master;
  localparam int unsigned DIV = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  uart_bus_master_if bus_if();

  uart_bus_master #(.CLKSPEED(1600), .BAUD(100)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .txd(txd), .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  data;
    int unsigned min_req;
  } acc_t;

  acc_t       exp_acc[$];
  logic [7:0] exp_tx[$];
  int         checks = 0;
  int         errors = 0;
  bit         gnt_tie = 1'b1;
  int unsigned gnt_delay = 0;
  int unsigned gnt_cnt = 0;
  int unsigned req_cnt = 0;
  bit         prev_cs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_acc(input logic rnw, input logic [15:0] a, input logic [7:0] d, input int unsigned mr);
    acc_t e;
    e.rnw = rnw; e.addr = a; e.data = d; e.min_req = mr;
    exp_acc.push_back(e);
  endtask

  // Grant model and bus monitor
  always @(negedge clk) begin
    acc_t e;
    if (gnt_tie) bus_if.bus_gnt = 1'b1;
    else if (!bus_if.bus_req) begin
      bus_if.bus_gnt = 1'b0;
      gnt_cnt = 0;
    end else begin
      if (gnt_cnt >= gnt_delay) bus_if.bus_gnt = 1'b1;
      gnt_cnt++;
    end
    if (!reset) begin
      if (prev_cs) begin
        check("cs_width", bus_if.cs, 1'b0);
        check("req_drop", bus_if.bus_req, 1'b0);
        check("rnw_idle", bus_if.rnw, 1'b1);
      end
      if (bus_if.cs === 1'b1) begin
        if (exp_acc.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cs: got addr %0h rnw %0b expected no access", bus_if.addr, bus_if.rnw);
        end else begin
          e = exp_acc.pop_front();
          check("acc_rnw", bus_if.rnw, e.rnw);
          check("acc_addr", bus_if.addr, e.addr);
          if (!e.rnw) check("acc_dout", bus_if.dout, e.data);
          check("req_hold", req_cnt >= e.min_req, 1'b1);
        end
      end
      prev_cs = bus_if.cs === 1'b1;
    end
    if (!bus_if.bus_req) req_cnt = 0;
    else if (!bus_if.cs) req_cnt++;
  end

  // Serial response monitor
  initial begin
    forever begin : mon
      logic [7:0] b;
      logic stp;
      @(negedge clk);
      if (!reset && txd === 1'b0) begin
        repeat (DIV / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = txd;
        end
        repeat (DIV) @(negedge clk);
        stp = txd;
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx: got %0h expected no byte", b);
        end else begin
          check("tx_byte", b, exp_tx.pop_front());
          check("tx_stop", stp, 1'b1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stp = 1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stp;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int unsigned n = 0;
    while ((exp_tx.size() != 0 || exp_acc.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_tx.size() != 0 || exp_acc.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d tx %0d acc pending expected 0 0", name, exp_tx.size(), exp_acc.size());
    end
    repeat (2 * DIV) @(negedge clk);
  endtask

  initial begin
    bus_if.din = 8'h00;
    repeat (5) @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_req", bus_if.bus_req, 1'b0);
    check("rst_cs", bus_if.cs, 1'b0);
    check("rst_rnw", bus_if.rnw, 1'b1);
    check("rst_addr", bus_if.addr, 16'h0000);
    check("rst_dout", bus_if.dout, 8'h00);
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (20 * DIV) @(negedge clk);

    // write with grant tied high
    push_acc(1'b0, 16'h1234, 8'hA5, 1);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
    wait_done("write");
`ifdef UART_BRIDGE_AUTOINC_EN
    check("addr_after_wr", bus_if.addr, 16'h1235);
`else
    check("addr_after_wr", bus_if.addr, 16'h1234);
`endif
    check("dout_hold", bus_if.dout, 8'hA5);

    // read with delayed grant
    gnt_tie = 1'b0; gnt_delay = 20; bus_if.din = 8'h5C;
    push_acc(1'b1, 16'h8000, 8'h00, 20);
    exp_tx.push_back(8'h5C);
    send_byte(8'h52); send_byte(8'h80); send_byte(8'h00);
    wait_done("read");
    gnt_tie = 1'b1;

    // unknown command
    exp_tx.push_back(8'h3F);
    send_byte(8'h00);
    wait_done("unknown");

    // abandoned write, then a clean read
    bus_if.din = 8'h3C;
    push_acc(1'b1, 16'h0001, 8'h00, 1);
    send_byte(8'h57); send_byte(8'h12);
    repeat (50 * DIV) @(negedge clk);
    exp_tx.push_back(8'h3C);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    wait_done("timeout");

    // framing error inside a command
    push_acc(1'b0, 16'hABCD, 8'h77, 1);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'hAB); send_byte(8'h55, 1'b0); send_byte(8'hCD); send_byte(8'h77);
    wait_done("framing");
    check("dout_framing", bus_if.dout, 8'h77);

    // top-of-map read then 'N'
    bus_if.din = 8'h99;
    push_acc(1'b1, 16'hFFFF, 8'h00, 1);
    exp_tx.push_back(8'h99);
    send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFF);
    wait_done("read_top");
`ifdef UART_BRIDGE_AUTOINC_EN
    push_acc(1'b1, 16'h0000, 8'h00, 1);
    exp_tx.push_back(8'h99);
`else
    exp_tx.push_back(8'h3F);
`endif
    send_byte(8'h4E);
    wait_done("next");
`ifdef UART_BRIDGE_AUTOINC_EN
    check("addr_wrap", bus_if.addr, 16'h0001);
`else
    check("addr_keep", bus_if.addr, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL have parameter CLKSPEED, default 26600000, main clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter DIVISOR, default CLKSPEED/BAUD, clk cycles per bit time.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 40, idle bit times tolerated between command bytes.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port rxd, input, 1, asynchronous serial in (host commands).
REQ-008 SHALL have port txd, output, 1, serial out (responses).
REQ-009 SHALL have port bus_req, output, 1, request for the CPU bus.
REQ-010 SHALL have port bus_gnt, input, 1, bus granted.
REQ-011 SHALL have port addr, output, 16, bus address.
REQ-012 SHALL have port dout, output, 8, write data.
REQ-013 SHALL have port din, input, 8, read data.
REQ-014 SHALL have ports cs (output, 1, access strobe) and rnw (output, 1, 1=read, 0=write).

Function
REQ-015 SHALL sync rxd through two flops, detect start on synchronized 1->0, sample bits at bit centres (first sample DIVISOR+DIVISOR/2 clks after edge), 8 data bits LSB first.
REQ-016 SHALL discard a byte whose stop bit samples 0 (framing error), parser state unchanged.
REQ-017 SHALL transmit idle-high frames: start 0, 8 data bits LSB first, stop 1, each bit DIVISOR clks; next frame may start immediately after stop.
REQ-018 SHALL parse states IDLE, ADDR_HI, ADDR_LO, DATA, ACCESS, RESP.
REQ-019 SHALL in IDLE accept 0x52 'R' -> ADDR_HI (read), 0x57 'W' -> ADDR_HI (write); any other byte -> transmit 0x3F '?', stay IDLE.
REQ-020 SHALL load addr[15:8] in ADDR_HI, addr[7:0] in ADDR_LO; read goes to ACCESS, write goes to DATA then ACCESS.
REQ-021 SHALL in ACCESS hold bus_req=1 until bus_gnt=1, then assert cs=1 exactly one clk with rnw, addr, dout stable; drop bus_req the following clk.
REQ-022 SHALL for reads latch din on the clk after cs, then transmit that byte; for writes transmit 0x4B 'K' after cs.
REQ-023 SHALL return to IDLE when response frame's stop bit completes; bytes received during ACCESS/RESP are dropped.
REQ-024 SHALL return to IDLE without bus access or response if TIMEOUT_BITS*DIVISOR clks elapse between bytes of one command.
REQ-025 SHALL keep cs=0, rnw=1 outside the single access clk; dout holds last written value.
REQ-026 SHALL wait indefinitely if bus_gnt never asserts (no timeout in ACCESS).

Reset
REQ-027 SHALL on reset force txd=1, bus_req=0, cs=0, rnw=1, addr=0, dout=0, parser IDLE, RX idle, abort any frame mid-bit.
REQ-028 SHALL ignore a start edge whose falling transition occurs during reset.

Configuration
REQ-029 SHALL with UART_BRIDGE_AUTOINC_EN defined increment addr (mod 2^16) after every access and accept 0x4E 'N' in IDLE: read at current addr, no address bytes.
REQ-030 SHALL without UART_BRIDGE_AUTOINC_EN leave addr unchanged after access and treat 0x4E as unknown ('?').

Verification
REQ-031 Send 'W',0x12,0x34,0xA5, bus_gnt tied 1 -> one cs pulse, rnw=0, addr=0x1234, dout=0xA5; txd returns 0x4B.
REQ-032 Send 'R',0x80,0x00, din=0x5C, bus_gnt delayed 20 clks -> bus_req held 20 clks, one cs with rnw=1; txd returns 0x5C.
REQ-033 Send 0x00 -> txd returns 0x3F, no cs.
REQ-034 Send 'W',0x12 then silence > TIMEOUT_BITS bit times, then 'R',0x00,0x01 -> single read at 0x0001 only.
REQ-035 Byte with stop bit 0 mid-command -> ignored; subsequent valid bytes complete command normally.
REQ-036 With UART_BRIDGE_AUTOINC_EN: 'R',0xFF,0xFF then 'N' -> reads at 0xFFFF then 0x0000; without: 'N' -> 0x3F.
